// File: rtl/rtc_seq_ctrl.sv
// rtc_seq_ctrl: steps an RTC register-access index through a read or write sequence with per-step timeout
module rtc_seq_ctrl #(
    parameter int IDX_W = 5,
    parameter int N_RD  = 21,
    parameter int N_WR  = 9,
    parameter int TO_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rw_mode,
    input  logic             abort,
    input  logic             Final_WR,
    output logic [IDX_W-1:0] ctrl_idx,
    output logic             tr_start,
    output logic             rw_o,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    localparam logic [IDX_W-1:0] LAST_RD = IDX_W'(N_RD);
    localparam logic [IDX_W-1:0] LAST_WR = IDX_W'(N_WR);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    // The counter is cleared in ISSUE and reads 0 in the first WAIT cycle, so the
    // limit cycle (2^TO_W-1 cycles of waiting) is the one where it holds 2^TO_W-2.
    localparam logic [TO_W-1:0]  TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] last_q;
    logic [TO_W-1:0]  cnt_q;
    logic             rw_q;
    logic             tr_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    // Sequencer: every output is registered and set on entry to the state it belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            tr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tr_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ISSUE;
                        idx_q   <= IDX_ONE;
                        rw_q    <= rw_mode;
                        last_q  <= rw_mode ? LAST_WR : LAST_RD;
                        tr_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (abort) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (Final_WR) begin
                        if (idx_q >= last_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            idx_q   <= idx_q + IDX_ONE;
                            tr_q    <= 1'b1;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE, ERR: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_idx = idx_q;
    assign tr_start = tr_q;
    assign rw_o     = rw_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rtc_seq_ctrl.sv
// tb_rtc_seq_ctrl: directed and randomized checks of rtc_seq_ctrl against a step-level reference model
module tb_rtc_seq_ctrl;

    localparam int IDX_W  = 5;
    localparam int NR     = 21;
    localparam int NW     = 9;
    localparam int TO_W   = 4;
    localparam int TO_LIM = 2 ** TO_W - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             rw_mode = 1'b0;
    logic             abort = 1'b0;
    logic             Final_WR = 1'b0;
    logic [IDX_W-1:0] ctrl_idx;
    logic             tr_start;
    logic             rw_o;
    logic             busy;
    logic             done;
    logic             err;

    rtc_seq_ctrl #(.IDX_W(IDX_W), .N_RD(NR), .N_WR(NW), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset), .start(start), .rw_mode(rw_mode), .abort(abort),
        .Final_WR(Final_WR), .ctrl_idx(ctrl_idx), .tr_start(tr_start), .rw_o(rw_o),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // reference model: m_idx=0 means idle; m_age counts cycles since the step's request
    // (0 = request cycle, 1..TO_LIM = waiting); m_end: 0 none, 1 done shown, 2 err shown
    int m_idx = 0, m_last = 0, m_rw = 0, m_age = 0, m_end = 0;

    int  since = 100;
    bit  obs_tr, obs_done, obs_err;
    int  obs_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got %0d want %0d at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic compare();
        chk("ctrl_idx", 32'(ctrl_idx), 32'(m_idx));
        chk("tr_start", 32'(tr_start), 32'(m_idx != 0 && m_end == 0 && m_age == 0));
        chk("rw_o",     32'(rw_o),     32'(m_rw));
        chk("busy",     32'(busy),     32'(m_idx != 0));
        chk("done",     32'(done),     32'(m_end == 1));
        chk("err",      32'(err),      32'(m_end == 2));
        obs_tr = tr_start; obs_done = done; obs_err = err; obs_idx = int'(ctrl_idx);
        since = tr_start ? 0 : since + 1;
    endtask

    task automatic model_edge(input logic s, input logic rw, input logic a, input logic f);
        if (m_idx == 0) begin
            if (s) begin
                m_idx = 1; m_age = 0; m_end = 0; m_rw = int'(rw); m_last = rw ? NW : NR;
            end
        end else if (m_end != 0 || a) begin
            m_idx = 0; m_end = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (f) begin
            if (m_idx == m_last) m_end = 1;
            else begin m_idx++; m_age = 0; end
        end else if (m_age == TO_LIM) begin
            m_end = 2;
        end else begin
            m_age++;
        end
    endtask

    task automatic step(input logic s, input logic rw, input logic a, input logic f);
        start = s; rw_mode = rw; abort = a; Final_WR = f;
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge(s, rw, a, f);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_idx"},  32'(ctrl_idx), 0);
        chk({tag, "_tr"},   32'(tr_start), 0);
        chk({tag, "_rw"},   32'(rw_o), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"},  32'(err), 0);
    endtask

    task automatic run_seq(input logic rw0, input int delay, input bit toggle, output int ntr, output bit ok);
        logic r;
        ntr = 0; ok = 0; since = 100;
        step(1'b1, rw0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            r = toggle ? i[0] : rw0;
            step(1'b0, r, 1'b0, since == delay - 1);
            if (obs_tr) ntr++;
            if (obs_done || obs_err) begin ok = obs_done; break; end
        end
    endtask

    initial begin
        int ntr, t_done, t_tr, cyc;
        bit ok, found;
        #3;
        check_all_zero("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_all_zero("post_rst");

        // read sequence, Final_WR 3 cycles after each request
        run_seq(1'b0, 3, 1'b0, ntr, ok);
        chk("rd_done", 32'(ok), 1);
        chk("rd_steps", 32'(ntr), NR);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rd_idle_idx", 32'(obs_idx), 0);

        // write sequence with rw_mode toggling after start
        run_seq(1'b1, 2, 1'b1, ntr, ok);
        chk("wr_done", 32'(ok), 1);
        chk("wr_steps", 32'(ntr), NW);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // timeout: no Final_WR at all
        step(1'b1, 1'b0, 1'b0, 1'b0);
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (obs_err) begin cyc = i; break; end
        end
        chk("to_cycles", 32'(cyc), TO_LIM + 1);
        chk("to_idx", 32'(obs_idx), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Final_WR on the last allowed waiting cycle succeeds
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= TO_LIM + 1; i++) step(1'b0, 1'b0, 1'b0, i == TO_LIM);
        chk("to_edge_tr", 32'(obs_tr), 1);
        chk("to_edge_idx", 32'(obs_idx), 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // abort together with Final_WR at index 5 while waiting
        since = 100;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200 && !(m_idx == 5 && m_age >= 1 && m_end == 0); i++)
            step(1'b0, 1'b0, 1'b0, since == 1);
        chk("abort_at5", 32'(m_idx), 5);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_idx", 32'(obs_idx), 0);
        chk("abort_tr", 32'(obs_tr), 0);
        chk("abort_done", 32'(obs_done), 0);

        // asynchronous reset at index 12
        since = 100;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400 && m_idx != 12; i++) step(1'b0, 1'b0, 1'b0, since == 1);
        chk("rst_at12", 32'(m_idx), 12);
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        m_idx = 0; m_last = 0; m_rw = 0; m_age = 0; m_end = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

        // protocol edges: Final_WR in ISSUE ignored, start during WAIT ignored
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("edge_idx2", 32'(obs_idx), 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // start held high: one idle cycle between sequences
        since = 100; t_done = -1; t_tr = -1; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, since == 0);
            if (obs_done && t_done < 0) t_done = i;
            if (obs_tr && t_done >= 0 && i > t_done) begin t_tr = i; found = 1; end
        end
        chk("b2b_gap", 32'(t_tr - t_done), 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // randomized traffic, alternating fast and slow transactor regimes
        for (int i = 0; i < 2400; i++) begin
            int fp;
            fp = ((i / 200) % 2 == 0) ? 2 : 20;
            step($urandom_range(7) == 0, 1'($urandom), $urandom_range(63) == 0,
                 $urandom_range(fp - 1) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got 0 want 1");
        $fatal(1, "watchdog");
    end

endmodule
